// File: rtl/c512to8_pkg.sv
// Shared constants, FSM state type and the per-word last-byte helper for c512to8.
package c512to8_pkg;

    localparam int BYTES_PER_WORD = 60;
    localparam int CTL_SOP_BIT    = 31;
    localparam int CTL_EOP_BIT    = 30;
    localparam int CTL_CNT_MSB    = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Index of the last byte to emit from a word; a zero or oversized count means a full word.
    function automatic logic [5:0] last_index(input logic eop_word, input logic [CTL_CNT_MSB:0] cnt);
        if (!eop_word || cnt == 6'd0 || cnt > 6'(BYTES_PER_WORD))
            return 6'(BYTES_PER_WORD - 1);
        return cnt - 6'd1;
    endfunction

endpackage

// File: rtl/word_fifo2.sv
// Two-entry word FIFO; push is ignored when full and pop is ignored when empty.
module word_fifo2 #(
    parameter int WIDTH = 512
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push)
                wr_ptr <= ~wr_ptr;
            if (do_pop)
                rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/c512to8.sv
// 512-bit word to byte-stream serializer with a two-word input buffer and pause handling.
// Optional packet counter output enabled by defining C512TO8_PKTCNT_EN.
//
// state | meaning
// IDLE  | no word loaded; waits for a buffered word and pause low
// SHIFT | word loaded; idx walks 0..last, one byte per unpaused edge
module c512to8
    import c512to8_pkg::*;
#(
    parameter int DATA_WIDTH = 480,
    parameter int CTRL_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_wr,
    input  logic [CTRL_WIDTH-1:0] in_ctl,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_rdy,
    input  logic                  pause,
    output logic [7:0]            data_out,
    output logic                  datavalid,
    output logic                  newpkt,
    output logic                  eop
`ifdef C512TO8_PKTCNT_EN
    ,
    output logic [7:0]            pktcount
`endif
);

    localparam int WORD_W = CTRL_WIDTH + DATA_WIDTH;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  pop;
    logic [WORD_W-1:0]     head;
    logic [CTRL_WIDTH-1:0] head_ctl;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  head_sop;
    logic                  head_eop;
    logic [5:0]            head_last;
    logic                  ctl_unused;

    state_t                state, state_next;
    logic [5:0]            idx, idx_next;
    logic [5:0]            last_q, last_next;
    logic                  cur_eop, cur_eop_next;
    logic [DATA_WIDTH-1:0] sreg, sreg_next;
    logic [7:0]            data_next;
    logic                  dv_next, np_next, eop_next;
    logic                  advance;
    logic                  at_last;

    word_fifo2 #(.WIDTH(WORD_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_wr),
        .pop   (pop),
        .wdata ({in_ctl, in_data}),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head)
    );

    assign in_rdy     = !fifo_full;
    assign head_ctl   = head[WORD_W-1 -: CTRL_WIDTH];
    assign head_data  = head[DATA_WIDTH-1:0];
    assign head_sop   = head_ctl[CTL_SOP_BIT];
    assign head_eop   = head_ctl[CTL_EOP_BIT];
    assign head_last  = last_index(head_eop, head_ctl[CTL_CNT_MSB:0]);
    assign ctl_unused = ^head_ctl[CTL_EOP_BIT-1:CTL_CNT_MSB+1];
    assign at_last    = (idx == last_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        advance    = 1'b0;
        if (!pause) begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = SHIFT;
                    end
                end
                SHIFT: begin
                    if (!at_last)
                        advance = 1'b1;
                    else if (!fifo_empty)
                        pop = 1'b1;
                    else
                        state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end

        data_next    = data_out;
        sreg_next    = sreg;
        idx_next     = idx;
        last_next    = last_q;
        cur_eop_next = cur_eop;
        dv_next      = 1'b0;
        np_next      = 1'b0;
        eop_next     = 1'b0;
        // A pop always loads, so back-to-back words stream without a gap.
        if (pop) begin
            data_next    = head_data[DATA_WIDTH-1 -: 8];
            sreg_next    = head_data << 8;
            idx_next     = 6'd0;
            last_next    = head_last;
            cur_eop_next = head_eop;
            dv_next      = 1'b1;
            np_next      = head_sop;
            eop_next     = head_eop && (head_last == 6'd0);
        end else if (advance) begin
            data_next = sreg[DATA_WIDTH-1 -: 8];
            sreg_next = sreg << 8;
            idx_next  = idx + 6'd1;
            dv_next   = 1'b1;
            eop_next  = cur_eop && ((idx + 6'd1) == last_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out  <= 8'd0;
            datavalid <= 1'b0;
            newpkt    <= 1'b0;
            eop       <= 1'b0;
            sreg      <= '0;
            idx       <= 6'd0;
            last_q    <= 6'd0;
            cur_eop   <= 1'b0;
        end else begin
            data_out  <= data_next;
            datavalid <= dv_next;
            newpkt    <= np_next;
            eop       <= eop_next;
            sreg      <= sreg_next;
            idx       <= idx_next;
            last_q    <= last_next;
            cur_eop   <= cur_eop_next;
        end
    end

`ifdef C512TO8_PKTCNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pktcount <= 8'd0;
        else if (eop_next)
            pktcount <= pktcount + 8'd1;
    end
`endif

endmodule

// File: tb/tb_c512to8.sv
// Self-checking bench for c512to8: byte stream compared against a queue-based packet model.
module tb_c512to8;

    localparam int DW = 480;
    localparam int CW = 32;
    localparam logic [31:0] SOP = 32'h8000_0000;
    localparam logic [31:0] EOP = 32'h4000_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_wr = 1'b0;
    logic [CW-1:0] in_ctl = '0;
    logic [DW-1:0] in_data = '0;
    logic          in_rdy;
    logic          pause = 1'b0;
    logic [7:0]    data_out;
    logic          datavalid;
    logic          newpkt;
    logic          eop;
`ifdef C512TO8_PKTCNT_EN
    logic [7:0]    pktcount;
`endif

    c512to8 #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_wr     (in_wr),
        .in_ctl    (in_ctl),
        .in_data   (in_data),
        .in_rdy    (in_rdy),
        .pause     (pause),
        .data_out  (data_out),
        .datavalid (datavalid),
        .newpkt    (newpkt),
        .eop       (eop)
`ifdef C512TO8_PKTCNT_EN
        ,
        .pktcount  (pktcount)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int accept_cyc = 0;
    int exp_pkts = 0;
    bit rand_pause_en = 1'b0;

    // entries are {newpkt, eop, byte}
    logic [9:0] exp_q[$];
    logic [9:0] obs_q[$];
    int         obs_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst && datavalid) begin
            obs_q.push_back({newpkt, eop, data_out});
            obs_cyc.push_back(cyc);
        end
    end

    always @(negedge clk) begin
        if (rand_pause_en)
            pause = ($urandom_range(0, 3) == 0);
    end

    // Reference: a word contributes its valid bytes in order, MSB byte first.
    function automatic void model_word(input logic [31:0] ctl, input logic [DW-1:0] data);
        int n;
        int c;
        logic s, e;
        s = ctl[31];
        e = ctl[30];
        c = int'(ctl[5:0]);
        if (!e || c == 0 || c > 60) n = 60;
        else n = c;
        for (int i = 0; i < n; i++)
            exp_q.push_back({(i == 0) && s, e && (i == n - 1), data[DW-1-8*i -: 8]});
        if (e) exp_pkts = (exp_pkts + 1) % 256;
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] d;
        for (int k = 0; k < DW / 32; k++)
            d[32*k +: 32] = $urandom;
        return d;
    endfunction

    function automatic int first_diff();
        int n;
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (obs_q[i] !== exp_q[i]) return i;
        if (obs_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    task automatic clear_q();
        exp_q.delete();
        obs_q.delete();
        obs_cyc.delete();
    endtask

    task automatic push_word(input logic [31:0] ctl, input logic [DW-1:0] data);
        int waited;
        waited = 0;
        while (!in_rdy && waited < 500) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_rdy) begin
            checks++; errors++;
            $display("FAIL push_timeout in_rdy=%0b required=1", in_rdy);
            return;
        end
        in_wr = 1'b1;
        in_ctl = ctl;
        in_data = data;
        model_word(ctl, data);
        @(posedge clk); #1;
        accept_cyc = cyc;
        in_wr = 1'b0;
    endtask

    task automatic wait_bytes(input int n);
        int w;
        w = 0;
        while (obs_q.size() < n && w < 3000) begin
            @(negedge clk); #1;
            w++;
        end
    endtask

    task automatic drain();
        wait_bytes(exp_q.size());
        repeat (4) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (data_out !== 8'd0) begin errors++; $display("FAIL reset_data_out got=%h exp=00", data_out); end
        checks++; if (datavalid !== 1'b0) begin errors++; $display("FAIL reset_datavalid got=%b exp=0", datavalid); end
        checks++; if (newpkt !== 1'b0 || eop !== 1'b0) begin errors++; $display("FAIL reset_flags newpkt=%b eop=%b exp=0,0", newpkt, eop); end
        checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL reset_in_rdy got=%b exp=1", in_rdy); end
`ifdef C512TO8_PKTCNT_EN
        checks++; if (pktcount !== 8'd0) begin errors++; $display("FAIL reset_pktcount got=%0d exp=0", pktcount); end
`endif
        @(negedge clk); rst = 1'b1;
        exp_pkts = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_single14();
        clear_q();
        push_word(SOP | EOP | 32'd14, rand_word());
        wait_bytes(14);
        @(negedge clk); #1;
        checks++; if (datavalid !== 1'b0) begin errors++; $display("FAIL single_dv_after got=%b exp=0", datavalid); end
        drain();
        checks++; if (obs_q.size() != 14) begin errors++; $display("FAIL single_len got=%0d exp=14", obs_q.size()); end
        checks++; if (first_diff() != -1) begin errors++; $display("FAIL single_stream first_diff=%0d exp=-1", first_diff()); end
        checks++; if (obs_cyc.size() == 0 || obs_cyc[0] != accept_cyc + 1) begin
            errors++; $display("FAIL single_latency got=%0d exp=%0d", (obs_cyc.size() != 0) ? obs_cyc[0] - accept_cyc : -1, 1);
        end
`ifdef C512TO8_PKTCNT_EN
        checks++; if (pktcount !== 8'd1) begin errors++; $display("FAIL single_pktcount got=%0d exp=1", pktcount); end
`endif
    endtask

    task automatic test_back_to_back();
        int low, w;
        bit gap;
        clear_q();
        push_word(SOP, rand_word());
        push_word(32'h0, rand_word());
        push_word(EOP | 32'd0, rand_word());
        checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL b2b_full_rdy got=%b exp=0", in_rdy); end
        low = 0; w = 0;
        while (obs_q.size() < 180 && w < 1000) begin
            @(negedge clk); #1;
            if (!in_rdy) low++;
            w++;
        end
        drain();
        checks++; if (low != 59) begin errors++; $display("FAIL b2b_rdy_low_cycles got=%0d exp=59", low); end
        checks++; if (first_diff() != -1) begin errors++; $display("FAIL b2b_stream first_diff=%0d exp=-1", first_diff()); end
        gap = 1'b0;
        for (int i = 1; i < obs_cyc.size(); i++)
            if (obs_cyc[i] != obs_cyc[0] + i) gap = 1'b1;
        checks++; if (gap || obs_cyc.size() != 180) begin errors++; $display("FAIL b2b_gapless gap=%0b bytes=%0d exp=0,180", gap, obs_cyc.size()); end
    endtask

    task automatic test_pause();
        int zeros, held_bad;
        clear_q();
        push_word(SOP | EOP | 32'd0, rand_word());
        wait_bytes(30);
        pause = 1'b1;
        zeros = 0; held_bad = 0;
        repeat (5) begin
            @(posedge clk); @(negedge clk); #1;
            if (!datavalid) zeros++;
            if (data_out !== exp_q[29][7:0]) held_bad++;
        end
        pause = 1'b0;
        drain();
        checks++; if (zeros != 5) begin errors++; $display("FAIL pause_dv_low got=%0d exp=5", zeros); end
        checks++; if (held_bad != 0) begin errors++; $display("FAIL pause_hold bad_cycles=%0d exp=0", held_bad); end
        checks++; if (obs_q.size() != 60) begin errors++; $display("FAIL pause_len got=%0d exp=60", obs_q.size()); end
        checks++; if (first_diff() != -1) begin errors++; $display("FAIL pause_stream first_diff=%0d exp=-1", first_diff()); end
    endtask

    task automatic test_one_byte();
        clear_q();
        push_word(SOP | EOP | 32'd1, rand_word());
        push_word(SOP | EOP | 32'd63, rand_word());
        drain();
        checks++; if (obs_q.size() != 61) begin errors++; $display("FAIL onebyte_len got=%0d exp=61", obs_q.size()); end
        checks++; if (obs_q.size() < 2 || obs_q[0][9:8] !== 2'b11 || obs_q[1][9] !== 1'b1) begin
            errors++; $display("FAIL onebyte_flags got=%b,%b exp=11,1", (obs_q.size() > 0) ? obs_q[0][9:8] : 2'bxx, (obs_q.size() > 1) ? obs_q[1][9] : 1'bx);
        end
        checks++; if (obs_cyc.size() < 2 || obs_cyc[1] != obs_cyc[0] + 1) begin errors++; $display("FAIL onebyte_gapless next_valid_delta wrong exp=1"); end
        checks++; if (first_diff() != -1) begin errors++; $display("FAIL onebyte_stream first_diff=%0d exp=-1", first_diff()); end
    endtask

    task automatic test_mid_sop();
        clear_q();
        push_word(SOP, rand_word());
        push_word(SOP | EOP | 32'd5, rand_word());
        drain();
        checks++; if (obs_q.size() != 65) begin errors++; $display("FAIL midsop_len got=%0d exp=65", obs_q.size()); end
        checks++; if (first_diff() != -1) begin errors++; $display("FAIL midsop_stream first_diff=%0d exp=-1", first_diff()); end
`ifdef C512TO8_PKTCNT_EN
        checks++; if (pktcount !== 8'(exp_pkts)) begin errors++; $display("FAIL midsop_pktcount got=%0d exp=%0d", pktcount, exp_pkts); end
`endif
    endtask

    task automatic test_reset_mid();
        clear_q();
        push_word(SOP | EOP | 32'd0, rand_word());
        push_word(SOP | EOP | 32'd0, rand_word());
        wait_bytes(20);
        rst = 1'b0;
        #1;
        checks++; if (data_out !== 8'd0 || datavalid !== 1'b0 || newpkt !== 1'b0 || eop !== 1'b0) begin
            errors++; $display("FAIL rstmid_outputs data=%h dv=%b np=%b eop=%b exp=00,0,0,0", data_out, datavalid, newpkt, eop);
        end
        checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL rstmid_in_rdy got=%b exp=1", in_rdy); end
        exp_pkts = 0;
        repeat (2) @(negedge clk);
        clear_q();
        rst = 1'b1;
        #1;
        push_word(SOP | EOP | 32'd10, rand_word());
        drain();
        checks++; if (obs_q.size() != 10) begin errors++; $display("FAIL rstmid_len got=%0d exp=10", obs_q.size()); end
        checks++; if (first_diff() != -1) begin errors++; $display("FAIL rstmid_stream first_diff=%0d exp=-1", first_diff()); end
    endtask

    task automatic test_random();
        int nw;
        logic [31:0] ctl;
        clear_q();
        rand_pause_en = 1'b1;
        for (int p = 0; p < 12; p++) begin
            nw = $urandom_range(1, 3);
            for (int w = 0; w < nw; w++) begin
                ctl = 32'($urandom_range(0, 63));
                if (w == 0 || $urandom_range(0, 7) == 0) ctl = ctl | SOP;
                if (w == nw - 1) ctl = ctl | EOP;
                push_word(ctl, rand_word());
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
        end
        wait_bytes(exp_q.size());
        rand_pause_en = 1'b0;
        @(negedge clk); #1;
        pause = 1'b0;
        drain();
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL random_len got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        checks++; if (first_diff() != -1) begin errors++; $display("FAIL random_stream first_diff=%0d exp=-1", first_diff()); end
`ifdef C512TO8_PKTCNT_EN
        checks++; if (pktcount !== 8'(exp_pkts)) begin errors++; $display("FAIL random_pktcount got=%0d exp=%0d", pktcount, exp_pkts); end
`endif
    endtask

    initial begin
        test_reset();
        test_single14();
        test_back_to_back();
        test_pause();
        test_one_byte();
        test_mid_sop();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
